// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the sequence-detecting arbiter:
//   state_t      - FSM states (IDLE, SHIFT, REPORT)
//   DEF_WORD_W   - default bits per request word
//   DEF_RUN_LEN  - default run length that forms a detection
package seq_det_pkg;

    localparam int DEF_WORD_W  = 8;
    localparam int DEF_RUN_LEN = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/run_detector.sv
// run_detector
// Flags a bit position when it completes a run of RUN_LEN identical bits.
// The run counter saturates at RUN_LEN, so a longer run keeps flagging on
// every further bit of the same value.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-high reset (clears history)
//   clr     - synchronous history clear (new word starting)
//   bit_in  - current bit
//   bit_en  - bit_in is valid this cycle and is consumed
//   hit     - combinational flag for the current bit
module run_detector #(
    parameter int RUN_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_en,
    output logic hit
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_next;
    logic          last_bit;

    // A zero run count means no history, so the incoming bit starts a
    // fresh run of one regardless of last_bit.
    always_comb begin
        run_next = CW'(1);
        if (run_cnt != '0 && bit_in == last_bit) begin
            run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 1'b1;
        end
        hit = bit_en && (run_next == RUN_MAX);
    end

    // Run history is only updated for consumed bits and wiped on clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (clr) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (bit_en) begin
            run_cnt  <= run_next;
            last_bit <= bit_in;
        end
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
// Round-robin arbiter between two requesters. A granted word is shifted
// MSB first through a run detector for WORD_W cycles, then the number of
// flagged positions is held as a result until the consumer accepts it.
// Ports:
//   clk, reset             - clock and asynchronous active-high reset
//   req_valid[1:0]         - per-requester word available
//   req_data0, req_data1   - request words
//   req_ready[1:0]         - one-hot accept strobe (IDLE only)
//   res_valid / res_ready  - result handshake
//   res_id                 - requester owning the result
//   res_hits               - number of flagged shift positions
//   busy                   - high whenever the FSM is not IDLE
//   det_out                - live detector flag
//   res_first              - index of first flag, WORD_W if none
//                            (only with SEQ_DET_FIRST_HIT_EN defined)
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter int  WORD_W  = DEF_WORD_W,
    parameter int  RUN_LEN = DEF_RUN_LEN,
    localparam int HW      = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [WORD_W-1:0] req_data0,
    input  logic [WORD_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [HW-1:0]     res_hits,
    output logic              busy,
    output logic              det_out
`ifdef SEQ_DET_FIRST_HIT_EN
    ,
    output logic [HW-1:0]     res_first
`endif
);

    localparam logic [HW-1:0] LAST_IDX = HW'(WORD_W - 1);
    localparam logic [HW-1:0] NO_HIT   = HW'(WORD_W);

    state_t            state;
    logic              last_grant;
    logic [WORD_W-1:0] shreg;
    logic [HW-1:0]     idx;
    logic              grant;
    logic              grant_id;
    logic              hit;
    logic              bit_en;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was
    // not granted last. Grants are only offered while IDLE.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
        grant     = (state == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (grant) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign bit_en  = (state == SHIFT);
    assign busy    = (state != IDLE);
    assign det_out = hit;

    run_detector #(
        .RUN_LEN(RUN_LEN)
    ) u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (grant),
        .bit_in(shreg[WORD_W-1]),
        .bit_en(bit_en),
        .hit   (hit)
    );

    // Main FSM. res_hits accumulates during SHIFT and is frozen in REPORT;
    // the transition into REPORT already includes the final bit's hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            shreg      <= '0;
            idx        <= '0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_hits   <= '0;
`ifdef SEQ_DET_FIRST_HIT_EN
            res_first  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        shreg      <= grant_id ? req_data1 : req_data0;
                        res_id     <= grant_id;
                        last_grant <= grant_id;
                        idx        <= '0;
                        res_hits   <= '0;
`ifdef SEQ_DET_FIRST_HIT_EN
                        res_first  <= NO_HIT;
`endif
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    idx   <= idx + 1'b1;
                    if (hit) begin
                        res_hits <= res_hits + 1'b1;
                    end
`ifdef SEQ_DET_FIRST_HIT_EN
                    if (hit && res_first == NO_HIT) begin
                        res_first <= idx;
                    end
`else
                    // No first-hit tracking in this build.
`endif
                    if (idx == LAST_IDX) begin
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter
// Directed bench for seq_det_arbiter: an 8-bit/run-4 instance covers
// latency, hit counts, round-robin ties, result stalling and mid-shift
// reset; a 4-bit/run-2 instance covers back-to-back requests.
// Works with or without SEQ_DET_FIRST_HIT_EN.
module tb_seq_det_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic       res_ready;
    logic [1:0] req_ready;
    logic       res_valid;
    logic       res_id;
    logic [3:0] res_hits;
    logic       busy;
    logic       det_out;
`ifdef SEQ_DET_FIRST_HIT_EN
    logic [3:0] res_first;
`endif

    logic [1:0] r4_valid;
    logic [3:0] r4_d0;
    logic [3:0] r4_d1;
    logic       r4_res_ready;
    logic [1:0] r4_ready;
    logic       r4_res_valid;
    logic       r4_res_id;
    logic [2:0] r4_hits;
    logic       r4_busy;
    logic       r4_det;
`ifdef SEQ_DET_FIRST_HIT_EN
    logic [2:0] r4_first;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_det_arbiter #(.WORD_W(8), .RUN_LEN(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data0(req_data0),
        .req_data1(req_data1),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_hits (res_hits),
        .busy     (busy),
        .det_out  (det_out)
`ifdef SEQ_DET_FIRST_HIT_EN
        ,
        .res_first(res_first)
`endif
    );

    seq_det_arbiter #(.WORD_W(4), .RUN_LEN(2)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .req_valid(r4_valid),
        .req_data0(r4_d0),
        .req_data1(r4_d1),
        .req_ready(r4_ready),
        .res_valid(r4_res_valid),
        .res_ready(r4_res_ready),
        .res_id   (r4_res_id),
        .res_hits (r4_hits),
        .busy     (r4_busy),
        .det_out  (r4_det)
`ifdef SEQ_DET_FIRST_HIT_EN
        ,
        .res_first(r4_first)
`endif
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offer a word from one requester, confirm the grant, complete the transfer.
    task automatic applyStimulus(input int id, input logic [7:0] data);
        if (id == 0) req_data0 = data; else req_data1 = data;
        req_valid[id] = 1'b1;
        #1;
        checkOutput("grant", req_ready, (id == 0) ? 1 : 2);
        stepCycle();
        req_valid[id] = 1'b0;
    endtask

    // Count cycles from the transfer edge until res_valid; no grant allowed meanwhile.
    task automatic waitResult(output int n);
        n = 1;
        while (!res_valid && n < 40) begin
            checkOutput("no_grant_busy", req_ready, 0);
            stepCycle();
            n++;
        end
    endtask

    task automatic releaseResult();
        res_ready = 1'b1;
        stepCycle();
        res_ready = 1'b0;
        checkOutput("idle_after_accept", {30'd0, busy, res_valid}, 0);
    endtask

    task automatic sendWord(input int id, input logic [7:0] data,
                            input int hits, input int first);
        int n;
        applyStimulus(id, data);
        waitResult(n);
        checkOutput("latency", n, 9);
        checkOutput("res_id", res_id, id);
        checkOutput("res_hits", res_hits, hits);
`ifdef SEQ_DET_FIRST_HIT_EN
        checkOutput("res_first", res_first, first);
`else
        if (first < 0) $display("[TB] unexpected first index");
`endif
        releaseResult();
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        stepCycle();
    endtask

    initial begin
        int n;
        int seen_valid;
        reset        = 1'b1;
        req_valid    = 2'b00;
        req_data0    = '0;
        req_data1    = '0;
        res_ready    = 1'b0;
        r4_valid     = 2'b00;
        r4_d0        = '0;
        r4_d1        = '0;
        r4_res_ready = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_res_hits", res_hits, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_det_out", det_out, 0);
`ifdef SEQ_DET_FIRST_HIT_EN
        checkOutput("rst_res_first", res_first, 0);
`endif
        reset = 1'b0;
        stepCycle();

        $display("[TB] single words");
        sendWord(0, 8'h00, 5, 3);
        sendWord(1, 8'hF0, 2, 3);
        sendWord(1, 8'h3C, 1, 5);
        sendWord(1, 8'hAA, 0, 8);

        $display("[TB] tie out of reset with stalled result");
        pulseReset();
        req_data0 = 8'hFF;
        req_data1 = 8'h0F;
        req_valid = 2'b11;
        #1;
        checkOutput("tie_grant0", req_ready, 1);
        stepCycle();
        req_valid = 2'b10;
        waitResult(n);
        checkOutput("tie_latency0", n, 9);
        checkOutput("tie_id0", res_id, 0);
        checkOutput("tie_hits0", res_hits, 5);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("stall_valid", res_valid, 1);
            checkOutput("stall_id", res_id, 0);
            checkOutput("stall_hits", res_hits, 5);
            checkOutput("stall_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        #1;
        checkOutput("no_grant_on_accept", req_ready, 0);
        stepCycle();
        res_ready = 1'b0;
        #1;
        checkOutput("tie_grant1", req_ready, 2);
        stepCycle();
        req_valid = 2'b00;
        waitResult(n);
        checkOutput("tie_latency1", n, 9);
        checkOutput("tie_id1", res_id, 1);
        checkOutput("tie_hits1", res_hits, 2);
        releaseResult();

        $display("[TB] reset during shift");
        applyStimulus(0, 8'h00);
        repeat (4) stepCycle();
        checkOutput("det_live_idx4", det_out, 1);
        checkOutput("busy_idx4", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_ready", req_ready, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_det", det_out, 0);
        checkOutput("mid_rst_hits", res_hits, 0);
        checkOutput("mid_rst_id", res_id, 0);
        stepCycle();
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (res_valid) seen_valid = 1;
        end
        checkOutput("no_result_after_rst", seen_valid, 0);
        req_valid = 2'b11;
        #1;
        checkOutput("tie_after_rst", req_ready, 1);
        req_valid = 2'b00;
        stepCycle();

        $display("[TB] back-to-back on 4-bit instance");
        r4_d0    = 4'b1001;
        r4_valid = 2'b01;
        #1;
        checkOutput("r4_grant", r4_ready, 1);
        for (int w = 0; w < 2; w++) begin
            stepCycle();
            n = 1;
            while (!r4_res_valid && n < 40) begin
                stepCycle();
                n++;
            end
            checkOutput("r4_latency", n, 5);
            checkOutput("r4_hits", r4_hits, 1);
            checkOutput("r4_id", r4_res_id, 0);
            checkOutput("r4_busy", r4_busy, 1);
`ifdef SEQ_DET_FIRST_HIT_EN
            checkOutput("r4_first", r4_first, 2);
`endif
            r4_res_ready = 1'b1;
            stepCycle();
            r4_res_ready = 1'b0;
            if (w == 1) r4_valid = 2'b00;
            #1;
            checkOutput("r4_regrant", r4_ready, (w == 0) ? 1 : 0);
        end
        checkOutput("r4_det_idle", r4_det, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_det_arbiter.md
SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

Interface
REQ-001 The block SHALL take parameter WORD_W, default 8, as the bits per request word (range 4..16).
REQ-002 The block SHALL take parameter RUN_LEN, default 4, as the count of identical consecutive bits that forms a detection (range 2..WORD_W).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  per-requester word-available flag.
REQ-006 req_data0, req_data1  input  WORD_W each  words from requesters 0 and 1.
REQ-007 req_ready  output  2  one-hot accept strobe; a word transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_id  output  1  requester index that owns the result.
REQ-011 res_hits  output  HW=ceil(log2(WORD_W+1))  detection count for the word.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 det_out  output  1  live detector output.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and REPORT.
REQ-015 In IDLE, req_ready SHALL be driven combinationally for exactly the granted requester, and the transfer SHALL capture the word, latch res_id and move to SHIFT.
REQ-016 Arbitration SHALL be round-robin: a sole valid requester wins; if both are valid, the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-017 req_ready SHALL be 0 in SHIFT and REPORT.
REQ-018 SHIFT SHALL last exactly WORD_W cycles and present one bit per cycle to the detector, MSB first (shift index 0 = MSB).
REQ-019 The detector SHALL flag at shift index k when bits k-RUN_LEN+1..k of the current word are all equal; run history SHALL be cleared on every grant and SHALL never span words.
REQ-020 res_hits SHALL count the shift indices that flag; a run longer than RUN_LEN SHALL flag at every index from its RUN_LEN-th bit onward.
REQ-021 After the last shift, the FSM SHALL enter REPORT and hold res_valid, res_id and res_hits stable until res_ready is high, then return to IDLE.
REQ-022 Latency SHALL be fixed: a word accepted at cycle 0 gives res_valid at cycle WORD_W+1.
REQ-023 A new grant SHALL NOT occur in the cycle that res_ready completes REPORT; the earliest next grant is the following IDLE cycle.
REQ-024 res_hits arithmetic SHALL be unsigned HW-bit and SHALL never saturate, since the maximum count is WORD_W-RUN_LEN+1.

Reset
REQ-025 Asserting reset SHALL, asynchronously, set the state to IDLE, req_ready=0, res_valid=0, res_id=0, res_hits=0, det_out=0, busy=0, last-grant=1 and clear detector history.
REQ-026 Reset during SHIFT or REPORT SHALL discard the in-flight word without producing a result.

Configuration
REQ-027 With SEQ_DET_FIRST_HIT_EN defined, the block SHALL add output res_first (HW bits) giving the shift index of the first flag, or WORD_W if no flag occurred, valid with res_valid and reset to 0.
REQ-028 Without SEQ_DET_FIRST_HIT_EN, the port SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-029 Package seq_det_pkg SHALL hold the state enum (IDLE, SHIFT, REPORT) and the default WORD_W/RUN_LEN constants.
REQ-030 A sub-module run_detector SHALL implement the detector: inputs clk, reset, clr, bit_in and bit_en; output hit; parameter RUN_LEN.

Verification
REQ-031 Requester 0 sends 8'h00 -> res_valid at cycle 9, res_id=0, res_hits=5 (res_first=3).
REQ-032 Requester 1 sends 8'hF0 -> res_hits=2 (res_first=3); 8'h3C -> res_hits=1 (res_first=5); 8'hAA -> res_hits=0 (res_first=8).
REQ-033 Both requesters valid out of reset with words 8'hFF and 8'h0F -> results in order: id 0 with hits 5, then id 1 with hits 2; req_ready strictly one-hot throughout.
REQ-034 res_ready held low for 5 cycles in REPORT -> outputs stay stable and no grant occurs; the next grant comes one cycle after res_ready.
REQ-035 Reset asserted at shift index 4 -> all outputs zero immediately, no result emitted, next tie granted to requester 0.
REQ-036 Back-to-back requests with WORD_W=4, RUN_LEN=2 and word 4'b1001 -> res_hits=1, latency 5 cycles.
